// File: rtl/query_mem_pkg.sv
// Shared types and constants for the query patch memory port-0 arbiter.
// Holds the patch geometry, the Wishbone address bit positions used for
// decode, the FSM state and owner enums, and a byte-enable mask helper.
package query_mem_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int PATCH_SIZE = 5;
  localparam int PW         = DATA_WIDTH * PATCH_SIZE;  // 55-bit patch
  localparam int ADDR_WIDTH = 9;
  localparam int HI_W       = PW - 32;                  // width of upper half

  // Wishbone byte-address layout: [31:12] region, [11:3] index, [2] half.
  localparam int HALF_BIT = 2;
  localparam int IDX_LSB  = 3;
  localparam int IDX_MSB  = IDX_LSB + ADDR_WIDTH - 1;
  localparam int DEC_LSB  = 12;

  typedef logic [PW-1:0] patch_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_MEM,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_ACK
  } state_t;

  typedef enum logic {
    OWN_DP = 1'b0,
    OWN_WB = 1'b1
  } owner_t;

  // Expand 4 byte enables into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_patch_packer.sv
// Wishbone word <-> patch packer.
// Holds the low (32-bit) and high (PW-32 bit) shadow registers that build up
// a full patch from two 32-bit Wishbone writes, and unpacks one half of a
// patch read from memory into a 32-bit word.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_wr_en           merge i_wdata into the shadow selected by i_wr_half
//   i_wr_half         0 = low shadow, 1 = high shadow
//   i_sel, i_wdata    Wishbone byte enables and write data
//   i_rd_half         half of i_rpatch to return on o_rdata
//   i_rpatch          patch read from memory
//   o_patch           {shadow_hi, shadow_lo}
//   o_rdata           selected half, high half zero-extended
module wb_patch_packer
  import query_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic        i_wr_half,
  input  logic [3:0]  i_sel,
  input  logic [31:0] i_wdata,
  input  logic        i_rd_half,
  input  patch_t      i_rpatch,
  output patch_t      o_patch,
  output logic [31:0] o_rdata
);

  logic [31:0]     r_lo;
  logic [HI_W-1:0] r_hi;
  logic [31:0]     w_mask;
  logic [31:0]     w_lo_merged;
  logic [HI_W-1:0] w_hi_merged;

  assign w_mask      = byte_mask(i_sel);
  assign w_lo_merged = (i_wdata & w_mask) | (r_lo & ~w_mask);
  // Write-data bits above the patch width simply have no shadow to land in.
  assign w_hi_merged = (i_wdata[HI_W-1:0] & w_mask[HI_W-1:0]) |
                       (r_hi & ~w_mask[HI_W-1:0]);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lo <= '0;
      r_hi <= '0;
    end else if (i_wr_en) begin
      if (i_wr_half) r_hi <= w_hi_merged;
      else           r_lo <= w_lo_merged;
    end
  end

  assign o_patch = {r_hi, r_lo};
  assign o_rdata = i_rd_half ? {{(32-HI_W){1'b0}}, i_rpatch[PW-1:32]}
                             : i_rpatch[31:0];

endmodule

// File: rtl/query_mem_wb_arbiter.sv
// Arbiter for write/read port 0 of the query patch memory.
// The port is owned either by the internal datapath (combinational
// pass-through of dp_*) or by a Wishbone classic slave that packs 32-bit
// word accesses into full patches. Ownership follows wb_mode but only
// changes while the Wishbone FSM is idle and no datapath read is in flight.
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wb_mode                 1 = Wishbone owns port 0, 0 = datapath
//   wbs_*                   Wishbone classic slave interface
//   dp_req/we/addr/wpatch   datapath request; dp_gnt while datapath owns port
//   dp_rvalid, dp_rpatch    datapath read return, READ_LATENCY after request
//   mem_*0                  memory port 0 (csb/web active-low)
//   wb_conflict_o           pulse: Wishbone hit while the datapath owns port
module query_mem_wb_arbiter
  import query_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wb_mode,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic                  dp_req,
  input  logic                  dp_we,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  input  patch_t                dp_wpatch,
  output logic                  dp_gnt,
  output logic                  dp_rvalid,
  output patch_t                dp_rpatch,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output patch_t                mem_wpatch0,
  input  patch_t                mem_rpatch0,
  output logic                  wb_conflict_o
);

  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t                  r_state;
  owner_t                  r_owner;
  logic                    r_ack;
  logic                    r_conflict;
  logic [31:0]             r_dat;
  logic                    r_csb;
  logic                    r_web;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_half;
  logic [LW-1:0]           r_lat;
  logic                    r_cyc_lost;
  logic [READ_LATENCY-1:0] r_rd_pipe;

  logic                  w_hit;
  logic                  w_half;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_shadow_we;
  logic                  w_dp_rd;
  logic                  w_rd_inflight;
  logic                  w_ack_ok;
  patch_t                w_patch;
  logic [31:0]           w_rdata;
  logic                  w_unused_adr;

  assign w_hit  = wbs_cyc_i & wbs_stb_i &
                  (wbs_adr_i[31:DEC_LSB] == BASE_ADDR[31:DEC_LSB]);
  assign w_half = wbs_adr_i[HALF_BIT];
  assign w_idx  = wbs_adr_i[IDX_MSB:IDX_LSB];
  assign w_unused_adr = ^wbs_adr_i[1:0];

  // Shadows only move for a write accepted while Wishbone owns the port;
  // conflict writes are dropped.
  assign w_shadow_we = (r_state == ST_IDLE) & w_hit & wbs_we_i & (r_owner == OWN_WB);

  assign w_dp_rd       = (r_owner == OWN_DP) & dp_req & ~dp_we;
  assign w_rd_inflight = |r_rd_pipe;
  // A cycle abandoned by the host still finishes its memory op, unacked.
  assign w_ack_ok      = wbs_cyc_i & ~r_cyc_lost;

  wb_patch_packer u_packer (
    .i_clk     (wb_clk_i),
    .i_rst     (wb_rst_i),
    .i_wr_en   (w_shadow_we),
    .i_wr_half (w_half),
    .i_sel     (wbs_sel_i),
    .i_wdata   (wbs_dat_i),
    .i_rd_half (r_half),
    .i_rpatch  (mem_rpatch0),
    .o_patch   (w_patch),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_owner    <= OWN_DP;
      r_ack      <= 1'b0;
      r_conflict <= 1'b0;
      r_dat      <= '0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_idx      <= '0;
      r_half     <= 1'b0;
      r_lat      <= '0;
      r_cyc_lost <= 1'b0;
    end else begin
      r_ack      <= 1'b0;
      r_conflict <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dat      <= '0;
          r_cyc_lost <= 1'b0;
          // Owner may only move when no transaction is starting this edge.
          if (!w_hit && !w_rd_inflight) r_owner <= owner_t'(wb_mode);
          if (w_hit) begin
            if (r_owner == OWN_DP) begin
              r_state    <= ST_ACK;
              r_ack      <= 1'b1;
              r_conflict <= 1'b1;
            end else if (wbs_we_i && w_half) begin
              r_state <= ST_WR_MEM;
              r_csb   <= 1'b0;
              r_web   <= 1'b0;
              r_idx   <= w_idx;
            end else if (wbs_we_i) begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= ST_RD_ISSUE;
              r_csb   <= 1'b0;
              r_web   <= 1'b1;
              r_idx   <= w_idx;
              r_half  <= w_half;
            end
          end
        end
        ST_WR_MEM: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_state <= ST_ACK;
          r_ack   <= w_ack_ok;
        end
        ST_RD_ISSUE: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_lat   <= LW'(READ_LATENCY - 1);
          r_state <= ST_RD_WAIT;
          if (!wbs_cyc_i) r_cyc_lost <= 1'b1;
        end
        ST_RD_WAIT: begin
          if (r_lat == '0) begin
            r_state <= ST_ACK;
            r_ack   <= w_ack_ok;
            r_dat   <= w_ack_ok ? w_rdata : 32'd0;
          end else begin
            r_lat <= r_lat - 1'b1;
            if (!wbs_cyc_i) r_cyc_lost <= 1'b1;
          end
        end
        ST_ACK: begin
          r_state    <= ST_IDLE;
          r_dat      <= '0;
          r_cyc_lost <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath read return pipe: one stage per cycle of memory latency.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe[0] <= w_dp_rd;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

  // Port 0 mux. Reset forces the idle values even while dp_* are active.
  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    mem_csb0    = 1'b1;
    mem_web0    = 1'b1;
    mem_addr0   = '0;
    mem_wpatch0 = '0;
    if (!wb_rst_i) begin
      if (r_owner == OWN_DP) begin
        mem_csb0    = ~dp_req;
        mem_web0    = ~dp_we;
        mem_addr0   = dp_addr;
        mem_wpatch0 = dp_wpatch;
      end else begin
        mem_csb0    = r_csb;
        mem_web0    = r_web;
        mem_addr0   = r_idx;
        mem_wpatch0 = w_patch;
      end
    end
  end

  assign dp_gnt        = (r_owner == OWN_DP) & ~wb_rst_i;
  assign dp_rvalid     = r_rd_pipe[READ_LATENCY-1];
  assign dp_rpatch     = dp_rvalid ? mem_rpatch0 : '0;
  assign wbs_ack_o     = r_ack;
  assign wbs_dat_o     = r_dat;
  assign wb_conflict_o = r_conflict;

endmodule

// File: tb/tb_query_mem_wb_arbiter.sv
// Directed testbench for query_mem_wb_arbiter with a 1-cycle memory model.
module tb_query_mem_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_mode;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dp_req, dp_we;
  logic [8:0]  dp_addr;
  logic [54:0] dp_wpatch;
  logic        dp_gnt, dp_rvalid;
  logic [54:0] dp_rpatch;
  logic        mem_csb0, mem_web0;
  logic [8:0]  mem_addr0;
  logic [54:0] mem_wpatch0;
  logic [54:0] mem_rpatch0;
  logic        wb_conflict_o;

  int n_checks = 0;
  int n_errors = 0;

  query_mem_wb_arbiter dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb_mode       (wb_mode),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .dp_req        (dp_req),
    .dp_we         (dp_we),
    .dp_addr       (dp_addr),
    .dp_wpatch     (dp_wpatch),
    .dp_gnt        (dp_gnt),
    .dp_rvalid     (dp_rvalid),
    .dp_rpatch     (dp_rpatch),
    .mem_csb0      (mem_csb0),
    .mem_web0      (mem_web0),
    .mem_addr0     (mem_addr0),
    .mem_wpatch0   (mem_wpatch0),
    .mem_rpatch0   (mem_rpatch0),
    .wb_conflict_o (wb_conflict_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous, read data valid the cycle after select.
  logic [54:0] mem [0:511];
  int          acc_cnt = 0;
  int          wr_cnt  = 0;
  int          conf_cnt = 0;
  logic [8:0]  last_wr_addr = '0;
  logic [54:0] last_wr_data = '0;

  initial mem_rpatch0 = '0;

  always @(posedge clk) begin
    if (!mem_csb0) begin
      acc_cnt <= acc_cnt + 1;
      if (!mem_web0) begin
        mem[mem_addr0] <= mem_wpatch0;
        wr_cnt         <= wr_cnt + 1;
        last_wr_addr   <= mem_addr0;
        last_wr_data   <= mem_wpatch0;
      end else begin
        mem_rpatch0 <= mem[mem_addr0];
      end
    end
    if (wb_conflict_o) conf_cnt <= conf_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One Wishbone classic access; called ~1 time unit after a rising edge.
  // lat = cycles from stb to visible ack, -1 if no ack within the bound.
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, input int flip_at,
                           output int lat, output logic [31:0] rdat, output logic gnt_at_ack);
    wbs_adr_i = adr;
    wbs_we_i  = we;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    lat = -1;
    rdat = '0;
    gnt_at_ack = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == flip_at) wb_mode = 1'b0;
      if (wbs_ack_o) begin
        lat = c;
        rdat = wbs_dat_o;
        gnt_at_ack = dp_gnt;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        g;
    int          acc_base, wr_base, conf_base, ack_seen;

    rst = 1'b1; wb_mode = 1'b0;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_dat_i = 0; wbs_adr_i = 0;
    dp_req = 0; dp_we = 0; dp_addr = 0; dp_wpatch = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_csb", mem_csb0, 1);
    check("rst_web", mem_web0, 1);
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_gnt", dp_gnt, 0);
    check("rst_rvalid", dp_rvalid, 0);
    check("rst_conflict", wb_conflict_o, 0);
    rst = 1'b0;
    #1;
    check("post_rst_gnt", dp_gnt, 1);

    // Datapath write then read of index 5
    @(posedge clk); #1;
    dp_req = 1; dp_we = 1; dp_addr = 9'd5; dp_wpatch = 55'h1;
    #1;
    check("dp_wr_csb", mem_csb0, 0);
    check("dp_wr_web", mem_web0, 0);
    check("dp_wr_addr", mem_addr0, 5);
    check("dp_wr_data", mem_wpatch0, 55'h1);
    @(posedge clk); #1;
    dp_we = 0;
    #1;
    check("dp_rd_csb", mem_csb0, 0);
    check("dp_rd_web", mem_web0, 1);
    check("dp_rd_early_valid", dp_rvalid, 0);
    @(posedge clk); #1;
    dp_req = 0;
    check("dp_rvalid", dp_rvalid, 1);
    check("dp_rpatch", dp_rpatch, 55'h1);
    check("dp_no_ack", wbs_ack_o, 0);
    @(posedge clk); #1;
    check("dp_rvalid_drop", dp_rvalid, 0);

    // Wishbone ownership
    wb_mode = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("wb_gnt", dp_gnt, 0);

    wr_base = wr_cnt;
    wb_access(32'h3000_0050, 1, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, g);
    check("wr_lo_lat", lat, 1);
    check("wr_lo_nomem", wr_cnt, wr_base);
    wb_access(32'h3000_0054, 1, 32'h007F_FFFF, 4'hF, 0, lat, rd, g);
    check("wr_hi_lat", lat, 2);
    check("wr_hi_cnt", wr_cnt, wr_base + 1);
    check("wr_hi_addr", last_wr_addr, 10);
    check("wr_hi_data", last_wr_data, 55'h7FFFFF_DEADBEEF);

    wb_access(32'h3000_0054, 0, 0, 4'hF, 0, lat, rd, g);
    check("rd_hi_lat", lat, 3);
    check("rd_hi_dat", rd, 32'h007F_FFFF);
    wb_access(32'h3000_0050, 0, 0, 4'hF, 0, lat, rd, g);
    check("rd_lo_lat", lat, 3);
    check("rd_lo_dat", rd, 32'hDEAD_BEEF);

    // Byte-merged partial writes into index 11 reuse persisting shadows
    wb_access(32'h3000_0058, 1, 32'h0000_AA00, 4'b0010, 0, lat, rd, g);
    check("bm_lo_lat", lat, 1);
    wb_access(32'h3000_005C, 1, 32'h0012_0000, 4'b0100, 0, lat, rd, g);
    check("bm_hi_lat", lat, 2);
    check("bm_addr", last_wr_addr, 11);
    check("bm_data", last_wr_data, 55'h12FFFF_DEADAAEF);
    wb_access(32'h3000_005C, 0, 0, 4'hF, 0, lat, rd, g);
    check("bm_rd_dat", rd, 32'h0012_FFFF);

    // Address outside the region is never acked
    acc_base = acc_cnt;
    wb_access(32'h3100_0050, 0, 0, 4'hF, 0, lat, rd, g);
    check("nohit_lat", lat, -1);
    check("nohit_mem", acc_cnt, acc_base);

    // Mode flip to DP during a read: read completes, owner changes after ack
    wb_access(32'h3000_0050, 0, 0, 4'hF, 1, lat, rd, g);
    check("flip_lat", lat, 3);
    check("flip_dat", rd, 32'hDEAD_BEEF);
    check("flip_gnt_at_ack", g, 0);
    check("flip_gnt_after", dp_gnt, 1);

    // Conflict: Wishbone hit while datapath owns the port
    acc_base  = acc_cnt;
    conf_base = conf_cnt;
    wb_access(32'h3000_0060, 1, 32'h1234_5678, 4'hF, 0, lat, rd, g);
    check("conf_wr_lat", lat, 1);
    check("conf_wr_pulse", conf_cnt, conf_base + 1);
    check("conf_wr_mem", acc_cnt, acc_base);
    wb_access(32'h3000_0054, 0, 0, 4'hF, 0, lat, rd, g);
    check("conf_rd_lat", lat, 1);
    check("conf_rd_dat", rd, 0);
    check("conf_rd_pulse", conf_cnt, conf_base + 2);

    // Reset during RD_WAIT
    wb_mode = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    wbs_adr_i = 32'h3000_0050; wbs_we_i = 0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    @(posedge clk); #1;
    check("rr_issue_csb", mem_csb0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    acc_base = acc_cnt;
    check("rr_csb", mem_csb0, 1);
    check("rr_web", mem_web0, 1);
    check("rr_gnt", dp_gnt, 0);
    ack_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) ack_seen++;
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    rst = 1'b0;
    #1;
    check("rr_no_ack", ack_seen, 0);
    check("rr_no_mem", acc_cnt, acc_base);
    check("rr_owner_dp", dp_gnt, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("rr_wb_gnt", dp_gnt, 0);
    wb_access(32'h3000_0054, 1, 32'h0000_0001, 4'b0001, 0, lat, rd, g);
    check("rr_shadow_lat", lat, 2);
    check("rr_shadow_data", last_wr_data, 55'h1_0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
